// File: rtl/writeback_stage_if.sv
// MEM->WB bundle for the writeback stage: MEM-stage results in, register file
// write port, forwarding info and retired-instruction count out.
interface writeback_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  // MEM-stage side
  logic             mem_valid;
  logic             stall;
  logic             flush;
  logic             reg_write_in;
  logic [4:0]       rd_in;
  logic [1:0]       wb_sel_in;
  logic [2:0]       load_funct3_in;
  logic [XLEN-1:0]  alu_result_in;
  logic [XLEN-1:0]  load_word_in;
  logic [XLEN-1:0]  pc_plus_4_in;

  // Register file / hazard unit side
  logic             en;
  logic [XLEN-1:0]  register_file_data;
  logic [4:0]       rd;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic [CNT_W-1:0] instret;

  modport master (
    output mem_valid, stall, flush, reg_write_in, rd_in, wb_sel_in,
           load_funct3_in, alu_result_in, load_word_in, pc_plus_4_in,
    input  en, register_file_data, rd, fwd_valid, fwd_rd, fwd_data, instret
  );

  modport slave (
    input  mem_valid, stall, flush, reg_write_in, rd_in, wb_sel_in,
           load_funct3_in, alu_result_in, load_word_in, pc_plus_4_in,
    output en, register_file_data, rd, fwd_valid, fwd_rd, fwd_data, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load extraction, writeback source select,
// register file write port, forwarding outputs and retired-instruction counter.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_stage_if.slave  wb
);
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic             r_valid;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [1:0]       r_wb_sel;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_alu_result;
  logic [XLEN-1:0]  r_load_word;
  logic [XLEN-1:0]  r_pc_plus_4;
  logic [CNT_W-1:0] r_instret;

  logic             w_retire;
  logic [7:0]       w_byte_lane [4];
  logic [15:0]      w_half_lane [2];
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load_data;
  logic [XLEN-1:0]  w_wb_data;
  logic             w_en;

  // An instruction leaves WB only when the stage advances normally.
  assign w_retire = r_valid & ~wb.stall & ~wb.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_wb_sel     <= 2'b00;
      r_funct3     <= 3'b000;
      r_alu_result <= '0;
      r_load_word  <= '0;
      r_pc_plus_4  <= '0;
    end else if (wb.flush) begin
      r_valid      <= 1'b0;
    end else if (!wb.stall) begin
      r_valid      <= wb.mem_valid;
      r_reg_write  <= wb.reg_write_in;
      r_rd         <= wb.rd_in;
      r_wb_sel     <= wb.wb_sel_in;
      r_funct3     <= wb.load_funct3_in;
      r_alu_result <= wb.alu_result_in;
      r_load_word  <= wb.load_word_in;
      r_pc_plus_4  <= wb.pc_plus_4_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign w_byte_lane[gi] = r_load_word[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign w_half_lane[gi] = r_load_word[16*gi +: 16];
    end
  endgenerate

  // Halfword lane uses only off[1]; misaligned halfwords are not trapped here.
  assign w_byte = w_byte_lane[r_alu_result[1:0]];
  assign w_half = w_half_lane[r_alu_result[1]];

  always_comb begin
    w_load_data = r_load_word;
    case (r_funct3)
      F3_LB:   w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = r_load_word;
    endcase
  end

  always_comb begin
    w_wb_data = r_alu_result;
    case (r_wb_sel)
      SEL_LOAD: w_wb_data = w_load_data;
      SEL_PC4:  w_wb_data = r_pc_plus_4;
      default:  w_wb_data = r_alu_result;
    endcase
  end

  // x0 is hardwired to zero, so writes to it are never enabled.
  assign w_en = r_valid & r_reg_write & (r_rd != 5'd0);

  assign wb.en                 = w_en;
  assign wb.rd                 = r_rd;
  assign wb.register_file_data = w_wb_data;
  assign wb.fwd_valid          = w_en;
  assign wb.fwd_rd             = r_rd;
  assign wb.fwd_data           = w_wb_data;
  assign wb.instret            = r_instret;
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the RV32I 5-stage core.
- Captures MEM-stage results and extracts and sign-extends load data.
- Selects the writeback source and drives the register file write port (en, register_file_data, rd).
- Also drives WB-stage forwarding info for the hazard unit and a retired-instruction counter.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage holds a real instruction
stall  in  1  hold MEM/WB register contents
flush  in  1  kill instruction entering WB (bubble)
reg_write_in  in  1  instruction writes rd
rd_in  in  5  destination register
wb_sel_in  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
load_funct3_in  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
alu_result_in  in  XLEN  ALU result / load effective address
load_word_in  in  XLEN  aligned 32-bit word read from data memory
pc_plus_4_in  in  XLEN  return address for JAL/JALR
en  out  1  register file write enable
register_file_data  out  XLEN  register file write data
rd  out  5  register file write address
fwd_valid  out  1  WB result forwardable (equals en)
fwd_rd  out  5  equals rd
fwd_data  out  XLEN  equals register_file_data
instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst_n=0, async): all stage registers 0, so valid_q=0, en=0, rd=0, register_file_data=0, fwd_*=0, instret=0. Reset mid-operation discards the in-flight instruction.
- Stage register update on each rising clk edge, with rst_n=1. Priority order:
  - flush=1: valid_q<=0; other fields don't care. Flush beats stall.
  - else stall=1: all fields hold.
  - else: capture all *_in fields; valid_q<=mem_valid.
- Latency: inputs captured at edge N drive outputs combinationally from edge N until the next update. One-cycle latency; no combinational path from *_in to outputs.
- en = valid_q & reg_write_q & (rd_q != 0). Writes to x0 are suppressed.
- rd = rd_q.
- Load extraction: byte offset off = alu_result_q[1:0].
  - LB/LBU: byte at lane off, bits [8*off+7:8*off].
  - LH/LHU: halfword at lane off[1]; off[0] is ignored (no misalignment trap in this core).
  - LW: whole word; off is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - funct3 011/110/111: treated as LW.
- Write data select:
  - wb_sel 00 or 11: alu_result_q.
  - 01: extracted load data.
  - 10: pc_plus_4_q.
- register_file_data is driven by this mux even when en=0. The register file ignores it.
- instret increments by 1 at each edge where valid_q=1 and stall=0 and flush=0 (instruction leaves WB). It is not incremented when an instruction is flushed while held in WB. It wraps modulo 2^CNT_W.
- While stall holds a valid writing instruction, en stays 1 and the register file rewrites the same value each cycle. This is idempotent and required.
- Simultaneous stall+flush: flush wins, and instret does not increment on that edge.

Test Plan:
- Reset then release, no stimulus -> en=0, rd=0, register_file_data=0, instret=0 for 5 cycles.
- ALU writeback: mem_valid=1, reg_write_in=1, rd_in=5, wb_sel=00, alu_result_in=0x0000_1234 -> one edge later en=1, rd=5, register_file_data=0x0000_1234. Next edge with mem_valid=0 -> instret=1, en=0.
- Loads from load_word_in=0x80F0_7F81:
  - LB off=0 -> 0xFFFF_FF81.
  - LBU off=0 -> 0x0000_0081.
  - LB off=1 -> 0x0000_007F.
  - LH off=2 -> 0xFFFF_80F0.
  - LHU off=3 -> 0x0000_80F0.
  - LW off=1 -> 0x80F0_7F81.
- JAL: wb_sel=10, pc_plus_4_in=0x0000_0104, rd_in=1 -> register_file_data=0x0000_0104, en=1. Same with rd_in=0 -> en=0, fwd_valid=0.
- Stall/flush:
  - Capture rd=7 value 0xA5A5_A5A5, then hold stall=1 for 3 cycles with new inputs changing -> outputs unchanged, en=1, instret unchanged.
  - Then assert stall=1 and flush=1 on the same edge -> en=0, instret unchanged.
- Async reset asserted mid-cycle while en=1 -> en, rd, register_file_data and instret go to 0 immediately, before the next clk edge.
